// File: rtl/urv_exceptions.sv
`default_nettype none
// ============================================================================
// Module      : urv_exceptions
// Description : Machine-mode trap and interrupt controller for the uRV core,
//               sitting in the X (execute) stage. Owns mstatus, mie, mip,
//               mepc and mcause. It decides trap entry and mret return, and
//               drives the pipeline redirect for both.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   TRAP_VECTOR          fetch address on trap entry (bits [1:0] must be 0)
//   IRQ_SYNC_STAGES      depth of the irq_i synchroniser, 2..3
// Ports:
//   clk_i                core clock
//   rst_i                asynchronous reset, active low
//   x_stall_i            X stage stalled, nothing commits
//   x_kill_i             X instruction squashed, no commit and no trap
//   x_valid_i            X holds a real instruction (not a bubble)
//   x_pc_i               PC of the X instruction
//   x_is_csr_i           X instruction is a CSR access
//   x_csr_sel_i          CSR address of the X instruction
//   x_csr_write_value_i  new CSR value computed by the CSR unit
//   x_is_mret_i          X instruction is mret
//   x_exception_i        X instruction raised a synchronous exception
//   x_exception_cause_i  exception cause code (2, 3 or 11)
//   irq_i                external interrupt, level, asynchronous
//   timer_tick_i         one-cycle pulse on timer compare match
//   csr_*_o              read values of the owned CSRs
//   x_redirect_o         kill younger instructions, fetch from x_redirect_pc_o
//   x_redirect_pc_o      TRAP_VECTOR on trap, mepc on mret
//   x_trap_taken_o       a trap is entered this cycle
// ============================================================================
module urv_exceptions #(
   parameter logic [31:0] TRAP_VECTOR     = 32'h0000_0008,
   parameter int          IRQ_SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        x_stall_i,
   input  logic        x_kill_i,
   input  logic        x_valid_i,
   input  logic [31:0] x_pc_i,
   input  logic        x_is_csr_i,
   input  logic [11:0] x_csr_sel_i,
   input  logic [31:0] x_csr_write_value_i,
   input  logic        x_is_mret_i,
   input  logic        x_exception_i,
   input  logic [3:0]  x_exception_cause_i,

   input  logic        irq_i,
   input  logic        timer_tick_i,

   output logic [31:0] csr_mstatus_o,
   output logic [31:0] csr_mip_o,
   output logic [31:0] csr_mie_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mcause_o,

   output logic        x_redirect_o,
   output logic [31:0] x_redirect_pc_o,
   output logic        x_trap_taken_o
);

   // CSR addresses handled here
   localparam logic [11:0] c_csr_mstatus = 12'h300;
   localparam logic [11:0] c_csr_mie     = 12'h304;
   localparam logic [11:0] c_csr_mepc    = 12'h341;
   localparam logic [11:0] c_csr_mcause  = 12'h342;
   localparam logic [11:0] c_csr_mip     = 12'h344;

   // Interrupt cause codes
   localparam logic [3:0]  c_cause_ext   = 4'd11;
   localparam logic [3:0]  c_cause_timer = 4'd7;

   // The vector is word aligned whatever the caller passes in
   localparam logic [31:0] c_trap_vector = {TRAP_VECTOR[31:2], 2'b00};

   // -------------------------------------------------------------------------
   // Architectural state
   // -------------------------------------------------------------------------
   logic                       r_mstatus_mie;
   logic                       r_mstatus_mpie;
   logic                       r_mie_mtie;
   logic                       r_mie_meie;
   logic                       r_mip_mtip;
   logic [29:0]                r_mepc;          // mepc[31:2]
   logic                       r_mcause_irq;
   logic [3:0]                 r_mcause_code;
   logic [IRQ_SYNC_STAGES-1:0] r_irq_sync;

   // -------------------------------------------------------------------------
   // Decision logic
   // -------------------------------------------------------------------------
   logic       w_meip;
   logic       w_commit;
   logic       w_int_ext;
   logic       w_int_timer;
   logic       w_trap_req;
   logic       w_trap_taken;
   logic       w_trap_is_irq;
   logic [3:0] w_trap_code;
   logic       w_mret_taken;
   logic       w_csr_we;
   logic       w_unused;

   assign w_meip      = r_irq_sync[IRQ_SYNC_STAGES-1];

   // Qualifying with rst_i makes the redirect drop the instant reset is
   // asserted, even though the X inputs may still look like a trap.
   assign w_commit    = rst_i & x_valid_i & ~x_stall_i & ~x_kill_i;

   assign w_int_ext   = r_mstatus_mie & r_mie_meie & w_meip;
   assign w_int_timer = r_mstatus_mie & r_mie_mtie & r_mip_mtip;

   // A request may exist during a stall; it only fires on a committing cycle,
   // so a stalled instruction keeps its slot until it can actually be replaced.
   assign w_trap_req   = rst_i & x_valid_i & ~x_kill_i
                       & (x_exception_i | w_int_ext | w_int_timer);
   assign w_trap_taken = w_trap_req & w_commit;

   // Priority: synchronous exception, then external, then timer
   always_comb begin
      w_trap_is_irq = 1'b0;
      w_trap_code   = x_exception_cause_i;
      if (!x_exception_i) begin
         w_trap_is_irq = 1'b1;
         w_trap_code   = w_int_ext ? c_cause_ext : c_cause_timer;
      end
   end

   // A trap swallows the X instruction entirely: no mret, no CSR write
   assign w_mret_taken = w_commit & ~w_trap_taken & x_is_mret_i;
   assign w_csr_we     = w_commit & ~w_trap_taken & ~x_is_mret_i & x_is_csr_i;

   // The saved PC is word aligned, so the low PC bits carry no information
   assign w_unused = ^x_pc_i[1:0];

   // -------------------------------------------------------------------------
   // irq_i synchroniser (runs regardless of commit)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_irq_sync <= '0;
      end else begin
         r_irq_sync <= {r_irq_sync[IRQ_SYNC_STAGES-2:0], irq_i};
      end
   end

   // -------------------------------------------------------------------------
   // MTIP: sticky, set by the timer tick even without a commit. A tick in
   // the same cycle as a clearing mip write keeps the bit set so that no
   // timer event is lost.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mip_mtip <= 1'b0;
      end else if (timer_tick_i) begin
         r_mip_mtip <= 1'b1;
      end else if (w_csr_we && (x_csr_sel_i == c_csr_mip)) begin
         r_mip_mtip <= x_csr_write_value_i[7];
      end
   end

   // -------------------------------------------------------------------------
   // mstatus / mie / mepc / mcause update
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie_mtie     <= 1'b0;
         r_mie_meie     <= 1'b0;
         r_mepc         <= '0;
         r_mcause_irq   <= 1'b0;
         r_mcause_code  <= '0;
      end else if (w_trap_taken) begin
         // For interrupts this is the PC of the replaced instruction, which
         // will be re-executed after mret.
         r_mepc         <= x_pc_i[31:2];
         r_mcause_irq   <= w_trap_is_irq;
         r_mcause_code  <= w_trap_code;
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (w_mret_taken) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_csr_we) begin
         case (x_csr_sel_i)
            c_csr_mstatus: begin
               r_mstatus_mie  <= x_csr_write_value_i[3];
               r_mstatus_mpie <= x_csr_write_value_i[7];
            end
            c_csr_mie: begin
               r_mie_mtie <= x_csr_write_value_i[7];
               r_mie_meie <= x_csr_write_value_i[11];
            end
            c_csr_mepc: begin
               r_mepc <= x_csr_write_value_i[31:2];
            end
            c_csr_mcause: begin
               r_mcause_irq  <= x_csr_write_value_i[31];
               r_mcause_code <= x_csr_write_value_i[3:0];
            end
            default: begin
               // mip is handled with MTIP; other addresses are not ours
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Read values (unimplemented bits read 0, MPP hardwired to machine mode)
   // -------------------------------------------------------------------------
   assign csr_mstatus_o = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0,
                           r_mstatus_mie, 3'b0};
   assign csr_mie_o     = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
   assign csr_mip_o     = {20'b0, w_meip, 3'b0, r_mip_mtip, 7'b0};
   assign csr_mepc_o    = {r_mepc, 2'b00};
   assign csr_mcause_o  = {r_mcause_irq, 27'b0, r_mcause_code};

   // -------------------------------------------------------------------------
   // Pipeline redirect
   // -------------------------------------------------------------------------
   assign x_trap_taken_o  = w_trap_taken;
   assign x_redirect_o    = w_trap_taken | w_mret_taken;
   assign x_redirect_pc_o = w_trap_taken ? c_trap_vector : csr_mepc_o;

endmodule
`default_nettype wire

// File: doc/urv_exceptions.md
Name: urv_exceptions

Overview:
- Machine-mode trap and interrupt controller for the uRV core, in the X stage.
- Owns mstatus, mie, mip, mepc and mcause, and supplies them read-only to the CSR read/modify unit.
- Consumes the CSR unit's computed write value to update its registers.
- Decides trap entry and mret return, and drives the pipeline redirect (kill plus target PC) for both.

Parameters:
- TRAP_VECTOR, 32'h00000008, fetch address on trap entry; bits [1:0] must be 0.
- IRQ_SYNC_STAGES, 2, flip-flop depth of the irq_i synchroniser; legal range 2..3.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset. Asynchronous, active-low.
- x_stall_i  in  1  X stage stalled; no commit this cycle.
- x_kill_i  in  1  X instruction is squashed; no commit, no trap.
- x_valid_i  in  1  X holds a real instruction, not a bubble.
- x_pc_i  in  32  PC of the X instruction.
- x_is_csr_i  in  1  X instruction is a CSR op.
- x_csr_sel_i  in  12  CSR address of the X instruction.
- x_csr_write_value_i  in  32  new CSR value from the CSR unit.
- x_is_mret_i  in  1  X instruction is mret.
- x_exception_i  in  1  X instruction raised a synchronous exception.
- x_exception_cause_i  in  4  cause code: 2 = illegal, 3 = ebreak, 11 = ecall.
- irq_i  in  1  external interrupt, level, asynchronous.
- timer_tick_i  in  1  one-cycle pulse, timer compare match.
- csr_mstatus_o  out  32  mstatus read value.
- csr_mip_o  out  32  mip read value.
- csr_mie_o  out  32  mie read value.
- csr_mepc_o  out  32  mepc read value.
- csr_mcause_o  out  32  mcause read value.
- x_redirect_o  out  1  combinational; kill younger instructions and fetch from x_redirect_pc_o.
- x_redirect_pc_o  out  32  combinational; TRAP_VECTOR on trap, mepc on mret.
- x_trap_taken_o  out  1  combinational; trap entered this cycle.

Behaviour:
- commit = x_valid_i & !x_stall_i & !x_kill_i. No state changes without commit, except the irq synchroniser and MTIP set.
- Register layout. Unimplemented bits read 0; writes to them are ignored.
  - mstatus: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired 2'b11.
  - mie: MTIE bit 7, MEIE bit 11.
  - mip: MTIP bit 7, MEIP bit 11.
  - mepc: bits [31:2] writable; [1:0] read 0.
  - mcause: bit 31 = interrupt flag, [3:0] = code, rest 0.
- Reset values:
  - MIE = 0, MPIE = 0, mie = 0, MTIP = 0, mepc = 0, mcause = 0, synchroniser = 0.
  - All outputs reflect these reset values; redirect and trap outputs are 0.
- MEIP: read-only, equals the last synchroniser stage. Latency from irq_i to MEIP is IRQ_SYNC_STAGES cycles.
- MTIP: sticky.
  - Set by timer_tick_i.
  - Cleared by a committed CSR write to mip with bit 7 = 0.
  - Tick and clear in the same cycle: set wins.
- int_pend = MIE & ((MEIE & MEIP) | (MTIE & MTIP)).
- Trap request = x_valid_i & !x_kill_i & (x_exception_i | int_pend). The trap is taken only when commit is also true.
- Trap priority: synchronous exception > external (code 11) > timer (code 7).
- On a taken trap:
  - x_redirect_o = 1, x_trap_taken_o = 1, x_redirect_pc_o = TRAP_VECTOR.
  - At the clock edge: mepc ← {x_pc_i[31:2], 2'b00}; mcause ← {int_flag, 27'b0, code}; MPIE ← MIE; MIE ← 0.
  - An interrupt replaces the X instruction; that instruction does not execute and its PC is saved.
- A trap suppresses any CSR write, mret effect or retirement of the X instruction in the same cycle.
- mret, committed and with no trap:
  - x_redirect_o = 1, x_redirect_pc_o = mepc (current value).
  - At the clock edge: MIE ← MPIE; MPIE ← 1.
- CSR write, committed and with no trap, x_is_csr_i = 1 and x_csr_sel_i one of mstatus, mie, mip, mepc, mcause:
  - The writable bits take x_csr_write_value_i at the clock edge.
  - mcause keeps bit 31 and bits [3:0] only.
  - The new value is visible on csr_*_o the next cycle.
- Write of MIE = 1 with an interrupt pending: the interrupt is taken on the next valid committing instruction, never the CSR instruction itself.
- Stall with a pending interrupt: outputs hold and no state changes. The trap fires on the first commit cycle.
- Bubble (x_valid_i = 0): no trap, even with int_pend = 1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the redirect deasserts.

Test Plan:
- Reset, then read all CSR outputs → mstatus = 32'h1800, others 0, x_redirect_o = 0.
- Illegal instruction (cause 2) committed at PC 32'h100, MIE = 1 → redirect to 32'h8; mepc = 32'h100, mcause = 32'h2, MIE = 0, MPIE = 1.
- mie = 32'h800 and MIE = 1; raise irq_i → trap on the first valid commit ≥ 2 cycles later; mcause = 32'h8000000B. Then mret at mepc → redirect to the saved PC, MIE = 1, MPIE = 1.
- timer_tick_i and a committed mip write of 0 in the same cycle → MTIP = 1. A later write of 0 → MTIP = 0.
- Exception and pending external interrupt in the same cycle → mcause = 32'h3 for ebreak; the exception wins.
- Pending interrupt with x_stall_i = 1 for 3 cycles, then a bubble → no trap and no state change; the trap fires on the next valid commit. Separately, CSR write to mepc of 32'h1237 → mepc reads 32'h1234.
